moxie_fetch_seq: RTL and testbench
==================================

MOXIE_FETCH_SEQ -- requirements
Module: moxie_fetch_seq

Interface
REQ-001 Parameter ADDR_W, default 17: width of byte address.
REQ-002 Parameter LIMIT_ADDR, default 17'h01F40 (8000): sequencing stops once pointer exceeds this.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  one-cycle pulse; begins sequencing at start_addr_i (honoured in IDLE or DONE only).
REQ-006 start_addr_i  input  ADDR_W  first instruction byte address.
REQ-007 mem_req_o  output  1  byte read request; held until mem_ack_i.
REQ-008 mem_addr_o  output  ADDR_W  byte address of current request.
REQ-009 mem_ack_i  input  1  read complete; mem_data_i valid this cycle.
REQ-010 mem_data_i  input  8  read byte.
REQ-011 valid_o  output  1  insn_o/data_o window valid to decoder.
REQ-012 insn_o  output  16  bytes ptr, ptr+1, big-endian (ptr in [15:8]).
REQ-013 data_o  output  32  bytes ptr+2..ptr+5, big-endian (ptr+2 in [31:24]).
REQ-014 ready_i  input  1  decoder accepts window this cycle.
REQ-015 len_i  input  3  byte length of accepted instruction; sampled only when valid_o and ready_i.
REQ-016 ptr_o  output  ADDR_W  current instruction address.
REQ-017 busy_o  output  1  high in FETCH or PRESENT.
REQ-018 done_o  output  1  high in DONE.
REQ-019 err_o  output  1  sticky illegal-length flag; cleared by reset or accepted start_i.

Function
REQ-020 States: IDLE, FETCH, PRESENT, DONE; encoding free.
REQ-021 IDLE: outputs quiescent; start_i -> ptr=start_addr_i, byte count=0, err_o=0, go FETCH.
REQ-022 FETCH: mem_req_o=1, mem_addr_o=ptr+count (mod 2^ADDR_W); on mem_ack_i store mem_data_i in window byte[count], count+1; ack with count=5 -> PRESENT next cycle.
REQ-023 One outstanding request max; mem_addr_o stable while mem_req_o high and not acked.
REQ-024 Request for next byte SHALL issue the cycle after ack (back-to-back 1-cycle acks give 6-cycle fill, valid_o on 7th cycle after FETCH entry).
REQ-025 PRESENT: valid_o=1; insn_o/data_o stable until accept; mem_req_o=0.
REQ-026 Accept (valid_o & ready_i) with len_i in 1..6: ptr_next = ptr+len_i mod 2^ADDR_W; ptr_next > LIMIT_ADDR -> DONE, else FETCH with count=0.
REQ-027 Accept with len_i = 0 or 7: err_o=1, ptr unchanged, go DONE.
REQ-028 valid_o deasserts the cycle after accept; no window re-presented without a full 6-byte refetch.
REQ-029 Pointer wrap: byte addresses ptr+k wrap modulo 2^ADDR_W; wrapped ptr_next compared as unsigned against LIMIT_ADDR.
REQ-030 start_i in FETCH or PRESENT ignored; in DONE same as IDLE.
REQ-031 DONE: done_o=1, no requests, holds until start_i or reset.
REQ-032 mem_ack_i outside FETCH ignored.

Reset
REQ-033 rst_i high at a clock edge -> IDLE, ptr=0, count=0, window=0, err_o=0, all outputs 0, at that edge regardless of state.
REQ-034 Reset during FETCH drops mem_req_o the next cycle; in-flight ack after reset ignored.

Verification
REQ-035 Memory bytes 0x1000..0x1005 = 01 02 03 04 05 06, 1-cycle ack, start_addr 0x1000 -> insn_o=0x0102, data_o=0x03040506, valid_o 7 cycles after start.
REQ-036 Accept with len_i=2 at ptr 0x1000 -> next fetch addresses 0x1002..0x1007, ptr_o=0x1002; len_i=6 -> ptr_o=0x1008.
REQ-037 ptr=0x1F3E, accept len_i=6 -> ptr 0x1F44 > 0x1F40 -> done_o=1, mem_req_o=0 thereafter.
REQ-038 Ack delayed 3 cycles per byte, ready_i held low 5 cycles in PRESENT -> mem_addr_o stable, window stable, single accept.
REQ-039 len_i=0 on accept -> err_o=1, done_o=1, ptr_o unchanged; next start_i clears err_o.
REQ-040 rst_i asserted mid-FETCH after 3 bytes -> next cycle all outputs 0, state IDLE; late mem_ack_i ignored.

Source files
------------

// File: rtl/moxie_fetch_seq.sv
// Moxie instruction fetch sequencer: fills a 6-byte window from a byte-wide
// memory, presents it to the decoder and advances by the accepted length.
module moxie_fetch_seq #(
  parameter int unsigned       ADDR_W     = 17,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = 17'h01F40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i,
  output logic              valid_o,
  output logic [15:0]       insn_o,
  output logic [31:0]       data_o,
  input  logic              ready_i,
  input  logic [2:0]        len_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  // Handshakes: a memory byte transfers on a cycle with mem_req_o && mem_ack_i,
  // and mem_addr_o holds until then; a window transfers on a cycle with
  // valid_o && ready_i, and insn_o/data_o hold until then.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [5:0][7:0]   win_q, win_d;
  logic              err_q, err_d;

  logic              start_ok;
  logic              accept;
  logic              len_ok;
  logic              last_byte;
  logic [ADDR_W-1:0] ptr_next;

  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept    = (state_q == S_PRESENT) && ready_i;
  assign len_ok    = (len_i != 3'd0) && (len_i != 3'd7);
  assign last_byte = (cnt_q == 3'd5);
  assign ptr_next  = ptr_q + ADDR_W'(len_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack_i && last_byte) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (accept) begin
          // Wrapped pointer is compared unsigned, so a wrap past the top lands low.
          if (!len_ok || (ptr_next > LIMIT_ADDR)) state_d = S_DONE;
          else                                    state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    win_d = win_q;
    err_d = err_q;
    if (start_ok) begin
      ptr_d = start_addr_i;
      cnt_d = 3'd0;
      err_d = 1'b0;
    end else if ((state_q == S_FETCH) && mem_ack_i) begin
      // Byte 0 lands in the top lane so the window reads big-endian.
      win_d[3'd5 - cnt_q] = mem_data_i;
      cnt_d               = cnt_q + 3'd1;
    end else if (accept) begin
      cnt_d = 3'd0;
      if (len_ok) ptr_d = ptr_next;
      else        err_d = 1'b1;
    end
  end

  always_comb begin
    mem_req_o = 1'b0;
    valid_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_PRESENT: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr_o = ptr_q + ADDR_W'(cnt_q);
  assign insn_o     = win_q[5:4];
  assign data_o     = win_q[3:0];
  assign ptr_o      = ptr_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_moxie_fetch_seq.sv
// Randomized bench for moxie_fetch_seq: a byte memory responder plus a
// transaction-level model of pointer, window, done and error behaviour.
`timescale 1ns/1ps
module tb_moxie_fetch_seq;

  localparam int            AW    = 17;
  localparam logic [AW-1:0] LIMIT = 17'h01F40;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic [7:0]    mem_data_i = 8'h00;
  logic          valid_o;
  logic [15:0]   insn_o;
  logic [31:0]   data_o;
  logic          ready_i = 1'b0;
  logic [2:0]    len_i = 3'd0;
  logic [AW-1:0] ptr_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  int            ack_dly = 0;
  bit            junk_ack = 1'b0;

  logic [AW-1:0] m_ptr = '0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;
  logic [15:0]   last_insn;
  logic [31:0]   last_data;

  moxie_fetch_seq dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .valid_o      (valid_o),
    .insn_o       (insn_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .len_i        (len_i),
    .ptr_o        (ptr_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin : watchdog
    #500000;
    check_eq("watchdog", 64'(0), 64'(1));
    report();
  end

  // ---------------- memory responder ----------------
  // Acks a request after ack_dly waiting cycles; records every acked address.
  initial begin : mem_model
    int            wait_c;
    bit            pend;
    logic [AW-1:0] pend_addr;
    wait_c = 0;
    pend = 1'b0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      mem_ack_i  = 1'b0;
      mem_data_i = 8'($urandom);
      if (junk_ack) begin
        mem_ack_i = 1'b1;
        pend = 1'b0;
        wait_c = 0;
      end else if (mem_req_o) begin
        if (pend) check_eq("addr_stable", 64'(mem_addr_o), 64'(pend_addr));
        if (wait_c >= ack_dly) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem[mem_addr_o];
          got_q.push_back(mem_addr_o);
          pend = 1'b0;
          wait_c = 0;
        end else begin
          pend = 1'b1;
          pend_addr = mem_addr_o;
          wait_c++;
        end
      end else begin
        pend = 1'b0;
        wait_c = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string pfx);
    check_eq({pfx, "_req"},   64'(mem_req_o),  64'(0));
    check_eq({pfx, "_addr"},  64'(mem_addr_o), 64'(0));
    check_eq({pfx, "_valid"}, 64'(valid_o),    64'(0));
    check_eq({pfx, "_insn"},  64'(insn_o),     64'(0));
    check_eq({pfx, "_data"},  64'(data_o),     64'(0));
    check_eq({pfx, "_ptr"},   64'(ptr_o),      64'(0));
    check_eq({pfx, "_busy"},  64'(busy_o),     64'(0));
    check_eq({pfx, "_done"},  64'(done_o),     64'(0));
    check_eq({pfx, "_err"},   64'(err_o),      64'(0));
  endtask

  task automatic pulse_start(input logic [AW-1:0] addr);
    got_q.delete();
    @(negedge clk);
    start_i = 1'b1;
    start_addr_i = addr;
    @(negedge clk);
    start_i = 1'b0;
    start_addr_i = AW'($urandom);
    m_ptr = addr;
    m_err = 1'b0;
    m_done = 1'b0;
    check_eq("start_busy", 64'(busy_o), 64'(1));
    check_eq("start_ptr",  64'(ptr_o),  64'(addr));
    check_eq("start_err",  64'(err_o),  64'(0));
    check_eq("start_done", 64'(done_o), 64'(0));
  endtask

  // Entered on the first cycle of a fetch; returns on the cycle after accept.
  task automatic do_insn(input int len, input int hold, input bit poke, input int next_dly);
    int            cyc;
    logic [AW-1:0] a;
    logic [47:0]   win;
    exp_q.delete();
    win = '0;
    for (int k = 0; k < 6; k++) begin
      a = m_ptr + AW'(k);
      exp_q.push_back(a);
      win = {win[39:0], mem[a]};
    end
    cyc = 1;
    while (!valid_o && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("fill_cycles", 64'(cyc), 64'(6 * (ack_dly + 1) + 1));
    if (!valid_o) report();
    check_eq("fetch_count", 64'(got_q.size()), 64'(6));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_eq("fetch_addr", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check_eq("insn", 64'(insn_o), 64'(win[47:32]));
    check_eq("data", 64'(data_o), 64'(win[31:0]));
    last_insn = insn_o;
    last_data = data_o;
    if (poke) begin
      start_i = 1'b1;
      start_addr_i = AW'($urandom);
      junk_ack = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      check_eq("hold_valid", 64'(valid_o),   64'(1));
      check_eq("hold_insn",  64'(insn_o),    64'(win[47:32]));
      check_eq("hold_data",  64'(data_o),    64'(win[31:0]));
      check_eq("hold_req",   64'(mem_req_o), 64'(0));
      check_eq("hold_ptr",   64'(ptr_o),     64'(m_ptr));
    end
    junk_ack = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b1;
    len_i = 3'(len);
    ack_dly = next_dly;
    @(negedge clk);
    ready_i = 1'b0;
    len_i = 3'($urandom);
    if (len >= 1 && len <= 6) begin
      m_ptr = m_ptr + AW'(len);
      if (m_ptr > LIMIT) m_done = 1'b1;
    end else begin
      m_err = 1'b1;
      m_done = 1'b1;
    end
    check_eq("acc_valid", 64'(valid_o),   64'(0));
    check_eq("acc_ptr",   64'(ptr_o),     64'(m_ptr));
    check_eq("acc_done",  64'(done_o),    64'(m_done));
    check_eq("acc_err",   64'(err_o),     64'(m_err));
    check_eq("acc_busy",  64'(busy_o),    64'(!m_done));
    check_eq("acc_req",   64'(mem_req_o), 64'(!m_done));
  endtask

  task automatic done_hold(input int n);
    junk_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("done_flag",  64'(done_o),    64'(1));
      check_eq("done_req",   64'(mem_req_o), 64'(0));
      check_eq("done_busy",  64'(busy_o),    64'(0));
      check_eq("done_valid", 64'(valid_o),   64'(0));
      check_eq("done_ptr",   64'(ptr_o),     64'(m_ptr));
      check_eq("done_err",   64'(err_o),     64'(m_err));
    end
    junk_ack = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) mem[17'h01000 + i] = 8'(i + 1);

    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_i = 1'b0;

    // Reference fill at 0x1000 with single-cycle acks.
    ack_dly = 0;
    pulse_start(17'h01000);
    do_insn(2, 0, 1'b0, 0);
    check_eq("ref_insn", 64'(last_insn), 64'(16'h0102));
    check_eq("ref_data", 64'(last_data), 64'(32'h03040506));
    check_eq("ref_ptr2", 64'(ptr_o), 64'(17'h01002));
    do_insn(6, 0, 1'b0, 2);
    check_eq("ref_ptr8", 64'(ptr_o), 64'(17'h01008));

    repeat (12)
      do_insn($urandom_range(1, 6), $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // Illegal lengths end the run with a sticky error.
    do_insn(0, 1, 1'b0, 1);
    done_hold(4);
    pulse_start(AW'($urandom_range(0, 17'h01E00)));
    do_insn(7, 2, 1'b1, 0);
    done_hold(2);

    // Past the limit, with slow acks and a slow decoder.
    ack_dly = 3;
    pulse_start(17'h01F3E);
    do_insn(6, 5, 1'b1, 0);
    done_hold(5);

    // Landing exactly on the limit keeps going; one more byte stops.
    ack_dly = 0;
    pulse_start(17'h01F3A);
    do_insn(6, 0, 1'b0, 2);
    do_insn(1, 1, 1'b0, 0);
    done_hold(2);

    // Address wrap past the top of the byte space.
    ack_dly = 1;
    pulse_start(17'h1FFFD);
    do_insn(6, 2, 1'b0, 0);
    check_eq("wrap_ptr", 64'(ptr_o), 64'(17'h00003));

    // Reset after three bytes of a fetch; late acks must be ignored.
    repeat (3) @(negedge clk);
    check_eq("mid_busy", 64'(busy_o), 64'(1));
    check_eq("mid_addr", 64'(mem_addr_o), 64'(17'h00006));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_zero("midrst");
    junk_ack = 1'b1;
    repeat (3) @(negedge clk);
    junk_ack = 1'b0;
    check_zero("late_ack");
    got_q.delete();
    m_ptr = '0;
    m_done = 1'b0;
    m_err = 1'b0;

    pulse_start(17'h01000);
    do_insn(2, 0, 1'b0, 0);
    check_eq("again_insn", 64'(last_insn), 64'(16'h0102));

    report();
  end

endmodule
